// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for a 5-stage pipeline with a multi-cycle M-unit.
// Define HAZARD_FWD_EN for operand forwarding; otherwise every RAW hazard stalls Decode.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MdStartE,
    input  logic       MdDivE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MdBusy,
    output logic       MdDone
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    md_state_t  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] load_val;
    logic       long_op;
    logic       md_stall;
    logic       lw_stall;
    logic       data_stall;
    logic       branch;
    logic       hold;

    function automatic logic src_hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
        return we && (rs != 5'd0) && (rs == rd);
    endfunction

    // Ops of two cycles skip BUSY entirely; longer ones count down the cycles between start and DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        long_op  = MdDivE ? (DIV_CYCLES > 2) : (MUL_CYCLES > 2);
        load_val = MdDivE ? DIV_LOAD : MUL_LOAD;
        case (state_q)
            IDLE: begin
                if (MdStartE) begin
                    if (long_op) begin
                        state_d = BUSY;
                        cnt_d   = load_val;
                    end else begin
                        state_d = DONE;
                        cnt_d   = 6'd0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 6'd1) begin
                    state_d = DONE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_stall = rst && (((state_q == IDLE) && MdStartE) || (state_q == BUSY));
    assign lw_stall = src_hit(Rs1D, RdE, ResultSrcE0) || src_hit(Rs2D, RdE, ResultSrcE0);

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (src_hit(rs, RdM, RegWriteM))
            return 2'b10;
        else if (src_hit(rs, RdW, RegWriteW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    logic unused_inputs;
    assign unused_inputs = RegWriteE;
    assign data_stall    = lw_stall;
    assign ForwardAE     = rst ? fwd_sel(Rs1E) : 2'b00;
    assign ForwardBE     = rst ? fwd_sel(Rs2E) : 2'b00;
`else
    logic raw_stall;
    logic unused_inputs;
    assign unused_inputs = ^{Rs1E, Rs2E};
    assign raw_stall = src_hit(Rs1D, RdE, RegWriteE) || src_hit(Rs2D, RdE, RegWriteE) ||
                       src_hit(Rs1D, RdM, RegWriteM) || src_hit(Rs2D, RdM, RegWriteM) ||
                       src_hit(Rs1D, RdW, RegWriteW) || src_hit(Rs2D, RdW, RegWriteW);
    assign data_stall = lw_stall || raw_stall;
    assign ForwardAE  = 2'b00;
    assign ForwardBE  = 2'b00;
`endif

    // Priority: M-unit stall, then taken branch, then data hazard; stall and flush stay disjoint per stage.
    always_comb begin
        branch = rst && PCSrcE && !md_stall;
        hold   = rst && data_stall && !PCSrcE && !md_stall;
        StallF = md_stall || hold;
        StallD = md_stall || hold;
        StallE = md_stall;
        FlushD = branch;
        FlushE = branch || hold;
        FlushM = md_stall;
        MdBusy = md_stall;
        MdDone = rst && (state_q == DONE);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl against a cycle-position model of the pipeline rules.
// Honours HAZARD_FWD_EN the same way the design does.
module tb_hazard_ctrl;

    localparam int MUL = 4;
    localparam int DIV = 33;

    localparam logic [11:0] V_ZERO   = 12'b000000_00_00_00;
    localparam logic [11:0] V_MDSTL  = 12'b111001_00_00_10;
    localparam logic [11:0] V_MDDONE = 12'b000000_00_00_01;
    localparam logic [11:0] V_DSTALL = 12'b110010_00_00_00;
    localparam logic [11:0] V_BRANCH = 12'b000110_00_00_00;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE, MdDivE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone;
    logic [1:0] ForwardAE, ForwardBE;

    int errors = 0;
    int checks = 0;
    int m_pos  = 0;
    int m_len  = MUL;

    wire [11:0] dut_vec = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                           ForwardAE, ForwardBE, MdBusy, MdDone};

    hazard_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MdStartE(MdStartE), .MdDivE(MdDivE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MdDone(MdDone)
    );

    always #5 clk = ~clk;

    // Model tracks which cycle (1..len) of the current M-op Execute is in; 0 means no op.
    function automatic int eff_pos();
        return (m_pos == 0 && MdStartE) ? 1 : m_pos;
    endfunction

    function automatic int eff_len();
        return (m_pos == 0) ? (MdDivE ? DIV : MUL) : m_len;
    endfunction

    function automatic logic pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef HAZARD_FWD_EN
        return ResultSrcE0 && RdE == r;
`else
        return (ResultSrcE0 && RdE == r) || (RegWriteE && RdE == r) ||
               (RegWriteM && RdM == r) || (RegWriteW && RdW == r);
`endif
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] r);
`ifdef HAZARD_FWD_EN
        if (r == 5'd0) return 2'b00;
        if (RegWriteM && RdM == r) return 2'b10;
        if (RegWriteW && RdW == r) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic logic [11:0] model_out();
        logic sf, sd, se, fd, fe, fm, busy, done;
        sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0;
        if (!rst) return V_ZERO;
        busy = eff_pos() != 0 && eff_pos() < eff_len();
        done = eff_pos() != 0 && eff_pos() == eff_len();
        if (busy) begin
            sf = 1; sd = 1; se = 1; fm = 1;
        end else if (PCSrcE) begin
            fd = 1; fe = 1;
        end else if (pending(Rs1D) || pending(Rs2D)) begin
            sf = 1; sd = 1; fe = 1;
        end
        return {sf, sd, se, fd, fe, fm, fwd_model(Rs1E), fwd_model(Rs2E), busy, done};
    endfunction

    always @(posedge clk) begin
        if (!rst)
            m_pos <= 0;
        else if (eff_pos() == 0 || eff_pos() == eff_len())
            m_pos <= 0;
        else
            m_pos <= eff_pos() + 1;
        m_len <= eff_len();
    end

    always @(negedge clk) begin
        checks++;
        if (dut_vec !== model_out()) begin
            errors++;
            $display("[TB] FAIL model_cmp @%0t: got %b expected %b", $time, dut_vec, model_out());
        end
    end

    task automatic check_output(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE, MdDivE} = '0;
    endtask

    task automatic mul_run(input string name);
        for (int c = 0; c < 5; c++) begin
            step();
            MdStartE = (c < 4);
            MdDivE   = 1'b0;
            @(negedge clk);
            if (c < 3)       check_output({name, "_stall"}, dut_vec, V_MDSTL);
            else if (c == 3) check_output({name, "_done"},  dut_vec, V_MDDONE);
            else             check_output({name, "_idle"},  dut_vec, V_ZERO);
        end
    endtask

    task automatic apply_stimulus();
        int stall_cnt;
        int done_at;

        // Reset holds every output low regardless of inputs.
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        MdStartE = 1'b1;
        PCSrcE   = 1'b1;
        @(negedge clk);
        check_output("reset_outputs", dut_vec, V_ZERO);
        step();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check_output("idle_after_reset", dut_vec, V_ZERO);

        mul_run("mul");

        stall_cnt = 0;
        done_at   = -1;
        for (int c = 0; c < 33; c++) begin
            step();
            MdStartE = 1'b1;
            MdDivE   = 1'b1;
            @(negedge clk);
            if (MdBusy) stall_cnt++;
            if (MdDone) done_at = c;
        end
        check_output("div_stall_cycles", 12'(stall_cnt), 12'd32);
        check_output("div_done_cycle", 12'(done_at), 12'd32);

        // Back-to-back multiply; a branch and load hazard mid-op must not flush.
        for (int c = 0; c < 4; c++) begin
            step();
            MdStartE    = 1'b1;
            MdDivE      = 1'b0;
            PCSrcE      = (c == 1);
            ResultSrcE0 = (c == 1);
            RdE         = (c == 1) ? 5'd5 : 5'd0;
            Rs1D        = (c == 1) ? 5'd5 : 5'd0;
            @(negedge clk);
            if (c < 3) check_output("b2b_mul_stall", dut_vec, V_MDSTL);
            else       check_output("b2b_mul_done", dut_vec, V_MDDONE);
        end
        step();
        clear_inputs();
        @(negedge clk);
        check_output("b2b_mul_idle", dut_vec, V_ZERO);

        step();
        ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        @(negedge clk);
        check_output("load_use_rs1", dut_vec, V_DSTALL);
        step();
        PCSrcE = 1'b1;
        @(negedge clk);
        check_output("load_use_branch", dut_vec, V_BRANCH);
        step();
        PCSrcE = 1'b0; Rs1D = 5'd0; Rs2D = 5'd5;
        @(negedge clk);
        check_output("load_use_rs2", dut_vec, V_DSTALL);
        step();
        RdE = 5'd0; Rs2D = 5'd0;
        @(negedge clk);
        check_output("load_x0", dut_vec, V_ZERO);
        step();
        clear_inputs();
        PCSrcE = 1'b1;
        @(negedge clk);
        check_output("branch_only", dut_vec, V_BRANCH);

        step();
        clear_inputs();
        RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7;
        @(negedge clk);
`ifdef HAZARD_FWD_EN
        check_output("fwd_a_mem", dut_vec, 12'b000000_10_00_00);
`else
        check_output("fwd_a_mem", dut_vec, V_ZERO);
`endif
        step();
        RegWriteM = 1'b0;
        @(negedge clk);
`ifdef HAZARD_FWD_EN
        check_output("fwd_a_wb", dut_vec, 12'b000000_01_00_00);
`else
        check_output("fwd_a_wb", dut_vec, V_ZERO);
`endif
        step();
        Rs1E = 5'd0;
        @(negedge clk);
        check_output("fwd_a_none", dut_vec, V_ZERO);
        step();
        RegWriteM = 1'b1; Rs2E = 5'd7;
        @(negedge clk);
`ifdef HAZARD_FWD_EN
        check_output("fwd_b_mem", dut_vec, 12'b000000_00_10_00);
`else
        check_output("fwd_b_mem", dut_vec, V_ZERO);
`endif
        step();
        clear_inputs();
        RdM = 5'd0; RegWriteM = 1'b1; Rs1E = 5'd0; Rs2E = 5'd0;
        @(negedge clk);
        check_output("fwd_x0", dut_vec, V_ZERO);

        step();
        clear_inputs();
        RdM = 5'd3; RegWriteM = 1'b1; Rs2D = 5'd3;
        @(negedge clk);
`ifdef HAZARD_FWD_EN
        check_output("raw_mem_rs2", dut_vec, V_ZERO);
`else
        check_output("raw_mem_rs2", dut_vec, V_DSTALL);
`endif
        step();
        clear_inputs();
        RdW = 5'd9; RegWriteW = 1'b1; Rs1D = 5'd9;
        @(negedge clk);
`ifdef HAZARD_FWD_EN
        check_output("raw_wb_rs1", dut_vec, V_ZERO);
`else
        check_output("raw_wb_rs1", dut_vec, V_DSTALL);
`endif

        // Reset during the second BUSY cycle must abort the op without a done pulse.
        step();
        clear_inputs();
        MdStartE = 1'b1;
        @(negedge clk);
        check_output("abort_start", dut_vec, V_MDSTL);
        step();
        @(negedge clk);
        check_output("abort_busy1", dut_vec, V_MDSTL);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_output("abort_in_reset", dut_vec, V_ZERO);
        step();
        rst      = 1'b1;
        MdStartE = 1'b0;
        @(negedge clk);
        check_output("abort_no_done", dut_vec, V_ZERO);
        mul_run("fresh_mul");

        step();
        clear_inputs();
        step();
    endtask

    initial begin
        apply_stimulus();
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: total cycles a multiply occupies Execute; legal range >= 2.
REQ-002 Parameter DIV_CYCLES, default 33: total cycles a divide/remainder occupies Execute; legal range >= 2.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in Execute.
REQ-007 RdM, RdW  in  5 each  destinations in Memory and Writeback.
REQ-008 RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes the register file.
REQ-009 ResultSrcE0  in  1  instruction in Execute is a load.
REQ-010 PCSrcE  in  1  taken branch/jump resolved in Execute.
REQ-011 MdStartE, MdDivE  in  1 each  M-extension op in Execute; MdDivE=1 selects DIV/REM latency.
REQ-012 StallF, StallD, StallE  out  1 each  hold PC, IF/ID and ID/EX registers.
REQ-013 FlushD, FlushE, FlushM  out  1 each  replace stage contents with a NOP bubble.
REQ-014 ForwardAE, ForwardBE  out  2 each  operand select: 00 regfile, 01 Writeback, 10 Memory.
REQ-015 MdBusy, MdDone  out  1 each  M-unit occupied; one-cycle completion pulse.

Function
REQ-016 M-unit FSM states: IDLE, BUSY, DONE; 6-bit down-counter CNT; N = DIV_CYCLES if MdDivE, else MUL_CYCLES, sampled at start.
REQ-017 IDLE with MdStartE=1: go BUSY with CNT=N-2 if N>2, else go DONE; otherwise remain IDLE.
REQ-018 BUSY: CNT==1 -> DONE; else CNT decrements by 1; MdStartE/MdDivE ignored.
REQ-019 DONE: unconditionally -> IDLE next cycle; MdStartE ignored in DONE (same instruction still in Execute).
REQ-020 mdStall = (IDLE and MdStartE) or BUSY; an N-cycle op therefore stalls N-1 cycles and MdDone=1 in the Nth.
REQ-021 MdBusy = mdStall; MdDone = 1 only in DONE.
REQ-022 mdStall drives StallF=StallD=StallE=1 and FlushM=1 (bubble into Memory every stalled cycle).
REQ-023 lwStall = ResultSrcE0 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D); drives StallF=StallD=1, FlushE=1.
REQ-024 PCSrcE=1 (and not mdStall) drives FlushD=FlushE=1 and suppresses lwStall in the same cycle.
REQ-025 mdStall has priority over lwStall and PCSrcE: while mdStall, FlushD=FlushE=0.
REQ-026 Stall and flush are never both asserted on the same stage register in one cycle.
REQ-027 ForwardAE=10 if RegWriteM, RdM!=0, RdM==Rs1E; else 01 if RegWriteW, RdW!=0, RdW==Rs1E; else 00; ForwardBE identical on Rs2E.
REQ-028 Register x0 never causes a stall or forward.
REQ-029 All stall, flush and forward outputs are combinational from inputs and FSM state, valid in the same cycle.

Reset
REQ-030 rst low at a posedge: FSM=IDLE, CNT=0.
REQ-031 While rst low, all outputs are 0.
REQ-032 Reset during BUSY aborts the op; no MdDone pulse is issued.

Configuration
REQ-033 Macro HAZARD_FWD_EN defined: forwarding per REQ-027, and RAW stalls only per REQ-023.
REQ-034 HAZARD_FWD_EN undefined: ForwardAE=ForwardBE=00; rawStall = nonzero Rs1D/Rs2D matching RdE (RegWriteE), RdM (RegWriteM) or RdW (RegWriteW); rawStall drives StallF=StallD=1, FlushE=1, with the same priority as lwStall.

Verification
REQ-035 MUL_CYCLES=4, MdStartE=1 at cycle 0 -> StallF/D/E=1 and FlushM=1 in cycles 0-2; MdDone=1 in cycle 3 only; IDLE in cycle 4.
REQ-036 MdDivE=1, DIV_CYCLES=33 -> exactly 32 stall cycles, then one MdDone pulse; back-to-back start in cycle 33 restarts cleanly.
REQ-037 Load RdE=5 with Rs1D=5 -> StallF=StallD=FlushE=1 one cycle; the same with PCSrcE=1 -> FlushD=FlushE=1, StallD=0.
REQ-038 RdM=RdW=7, both writing, Rs1E=7 -> ForwardAE=10; RegWriteM=0 -> 01; Rs1E=0 -> 00.
REQ-039 rst low in the 2nd BUSY cycle -> next cycle all outputs 0, no MdDone; a fresh op after release runs its full length.
REQ-040 Build without HAZARD_FWD_EN, RdM=3 with RegWriteM=1, Rs2D=3 -> StallD=1, FlushE=1, ForwardBE=00.
